// File: rtl/imem_loader_if.sv
// Host-side bus between an instruction-memory loader and its environment.
// The master drives the load request and the source words. The slave
// (imem_loader) drives the imem write port and the status flags.
// The checksum signal exists only when IMEM_LOADER_CHECKSUM_EN is defined.
interface imem_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              write_to_imem;
  logic [ADDR_W-1:0] addr_imem_host;
  logic [DATA_W-1:0] imem_data;
  logic              busy;
  logic              done;
  logic              error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;

  modport master (
    output start, abort, base_addr, word_count, in_valid, in_data,
    input  in_ready, write_to_imem, addr_imem_host, imem_data, busy, done, error, checksum
  );
  modport slave (
    input  start, abort, base_addr, word_count, in_valid, in_data,
    output in_ready, write_to_imem, addr_imem_host, imem_data, busy, done, error, checksum
  );
`else
  modport master (
    output start, abort, base_addr, word_count, in_valid, in_data,
    input  in_ready, write_to_imem, addr_imem_host, imem_data, busy, done, error
  );
  modport slave (
    input  start, abort, base_addr, word_count, in_valid, in_data,
    output in_ready, write_to_imem, addr_imem_host, imem_data, busy, done, error
  );
`endif
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader. It streams word_count source words into imem.
// The words are written from base_addr upward, one write per accepted word.
// Requests that would run past the top of imem are refused with a sticky
// error flag. Every accepted start ends with exactly one done pulse.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add an XOR checksum
// of the words accepted since the last accepted start.
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              wr_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic [CNT_W-1:0]  end_addr_s;
  logic              accept_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;
`endif

  // One past the last requested address. It is one bit wider than the
  // address, so a load that ends exactly at the top of imem is legal.
  assign end_addr_s = {1'b0, bus.base_addr} + bus.word_count;

  // in_ready depends combinationally on abort, so an aborting cycle
  // can never also accept a word.
  assign bus.in_ready = (state_r == LOAD) && !bus.abort;
  assign accept_s     = bus.in_valid && bus.in_ready;

  assign bus.write_to_imem  = wr_r;
  assign bus.addr_imem_host = addr_r;
  assign bus.imem_data      = data_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.error          = error_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.checksum       = checksum_r;
`endif

  // Control FSM together with the registered imem write port and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {ADDR_W{1'b0}};
      cnt_r      <= CNT_ZERO;
      addr_r     <= {ADDR_W{1'b0}};
      data_r     <= {DATA_W{1'b0}};
      wr_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum_r <= {DATA_W{1'b0}};
`endif
    end else begin
      wr_r   <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            error_r <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_r <= {DATA_W{1'b0}};
`endif
            if (bus.word_count == CNT_ZERO) begin
              done_r <= 1'b1;
            end else if (end_addr_s > MEM_WORDS) begin
              error_r <= 1'b1;
              done_r  <= 1'b1;
            end else begin
              state_r <= LOAD;
              busy_r  <= 1'b1;
              ptr_r   <= bus.base_addr;
              cnt_r   <= bus.word_count;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (accept_s) begin
            wr_r   <= 1'b1;
            addr_r <= ptr_r;
            data_r <= bus.in_data;
            ptr_r  <= ptr_r + PTR_ONE;
            cnt_r  <= cnt_r - CNT_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_r <= checksum_r ^ bus.in_data;
`endif
            if (cnt_r == CNT_ONE) begin
              state_r <= FLUSH;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        FLUSH: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. It uses a table of load requests
// with expected outcomes, randomized requests, and a few hand-timed
// sequences. A request-level model predicts the list of imem writes, the
// done pulse and the error flag. A negedge monitor records what the DUT did.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  imem_loader_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  imem_loader #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [8:0]  mon_addr[$];
  logic [31:0] mon_data[$];
  bit          mon_done[$];
  bit          mon_busy[$];

  // Record every imem write, done pulse and busy cycle seen mid-cycle.
  always @(negedge clk) begin
    if (bus.write_to_imem) begin
      mon_addr.push_back(bus.addr_imem_host);
      mon_data.push_back(bus.imem_data);
    end
    if (bus.done) mon_done.push_back(1'b1);
    if (bus.busy) mon_busy.push_back(1'b1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    mon_addr.delete();
    mon_data.delete();
    mon_done.delete();
    mon_busy.delete();
  endtask

  task automatic do_start(input int base, input int wc);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = base[8:0];
    bus.word_count = wc[9:0];
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  // One complete load request, checked against a request-level model.
  // vmode selects the in_valid pattern: 0 = always, 1 = toggle, 2 = random.
  // abort_after gives the number of accepted words before abort; -1 means never.
  task automatic txn(input int base, input int wc, input int vmode, input int abort_after,
                     output int nwr, output int err);
    logic [8:0]  ea[$];
    logic [31:0] ed[$];
    logic [31:0] cs;
    logic [31:0] d;
    int accepted, cyc, budget;
    bit fin, v, ab, load, e;
    e        = ((base + wc) > 512);
    load     = (wc != 0) && !e;
    cs       = 32'h0;
    accepted = 0;
    cyc      = 0;
    fin      = 1'b0;
    budget   = 8 * wc + 64;
    mon_clear();
    do_start(base, wc);
    if (load) begin
      while (!fin) begin
        v  = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
        ab = (abort_after >= 0) && (accepted == abort_after);
        d  = $urandom;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.abort    = ab;
        @(negedge clk);
        check("in_ready", bus.in_ready, !ab);
        @(posedge clk);
        if (ab) begin
          fin = 1'b1;
        end else if (v) begin
          ea.push_back(9'(base + accepted));
          ed.push_back(d);
          cs = cs ^ d;
          accepted++;
          if (accepted == wc) fin = 1'b1;
        end
        cyc++;
        if (!fin && cyc > budget) begin
          checks++;
          errors++;
          $display("FAIL timeout: load of %0d words still running after %0d cycles", wc, cyc);
          fin = 1'b1;
        end
        #1;
      end
      bus.in_valid = 1'b0;
      bus.abort    = 1'b0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("nwrites", mon_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < mon_addr.size(); i++) begin
      check("wr_addr", mon_addr[i], ea[i]);
      check("wr_data", mon_data[i], ed[i]);
    end
    check("done_pulses", mon_done.size(), 1);
    check("error", bus.error, e);
    check("busy_end", bus.busy, 1'b0);
    check("busy_seen", mon_busy.size() != 0, load);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("checksum", bus.checksum, cs);
`endif
    nwr = mon_addr.size();
    err = bus.error;
  endtask

  typedef struct {
    int base;
    int wc;
    int vmode;
    int abort_after;
    int exp_nwr;
    int exp_err;
  } vec_t;

  vec_t        tbl[9];
  logic [31:0] w4[4];

  initial begin
    int nw, er;
    tbl[0] = '{0,     4,     0, -1, 4,   0};
    tbl[1] = '{'h1FE, 2,     0, -1, 2,   0};
    tbl[2] = '{'h1FF, 2,     0, -1, 0,   1};
    tbl[3] = '{5,     0,     0, -1, 0,   0};
    tbl[4] = '{'h10,  3,     1, -1, 3,   0};
    tbl[5] = '{'h20,  8,     0,  3, 3,   0};
    tbl[6] = '{'h100, 'h101, 0, -1, 0,   1};
    tbl[7] = '{'h100, 'h100, 2, -1, 256, 0};
    tbl[8] = '{0,     512,   0, -1, 512, 0};
    w4[0] = 32'h11; w4[1] = 32'h22; w4[2] = 32'h33; w4[3] = 32'h44;

    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = 9'h0; bus.word_count = 10'h0;
    bus.in_valid = 1'b0; bus.in_data = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr", bus.write_to_imem, 1'b0);
    check("rst_addr", bus.addr_imem_host, 9'h0);
    check("rst_data", bus.imem_data, 32'h0);
    check("rst_ready", bus.in_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_error", bus.error, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Exact cycle timing of a four-word back-to-back load
    do_start(0, 4);
    bus.in_valid = 1'b1;
    bus.in_data  = w4[0];
    @(negedge clk);
    check("b2b_ready", bus.in_ready, 1'b1);
    check("b2b_nowr", bus.write_to_imem, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) bus.in_data = w4[i+1];
      else bus.in_valid = 1'b0;
      @(negedge clk);
      check("b2b_wr", bus.write_to_imem, 1'b1);
      check("b2b_addr", bus.addr_imem_host, 9'(i));
      check("b2b_data", bus.imem_data, w4[i]);
      check("b2b_busy", bus.busy, 1'b1);
      check("b2b_done_low", bus.done, 1'b0);
    end
    check("flush_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    check("b2b_end_wr", bus.write_to_imem, 1'b0);
    check("b2b_done", bus.done, 1'b1);
    check("b2b_idle", bus.busy, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("b2b_checksum", bus.checksum, 32'h44);
`endif
    @(negedge clk);
    check("b2b_done_once", bus.done, 1'b0);

    // Table-driven requests
    for (int i = 0; i < 9; i++) begin
      txn(tbl[i].base, tbl[i].wc, tbl[i].vmode, tbl[i].abort_after, nw, er);
      check("tbl_nwrites", nw, tbl[i].exp_nwr);
      check("tbl_error", er, tbl[i].exp_err);
    end

    // A start while busy is ignored; the original base is used
    mon_clear();
    do_start('h40, 2);
    bus.start = 1'b1; bus.base_addr = 9'h80; bus.word_count = 10'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'hA5A5_0001;
    @(posedge clk); #1;
    bus.in_data = 32'hA5A5_0002;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("busy_start_nwr", mon_addr.size(), 2);
    if (mon_addr.size() == 2) begin
      check("busy_start_a0", mon_addr[0], 9'h40);
      check("busy_start_a1", mon_addr[1], 9'h41);
      check("busy_start_d1", mon_data[1], 32'hA5A5_0002);
    end
    check("busy_start_done", mon_done.size(), 1);

    // Abort during FLUSH or IDLE has no effect
    mon_clear();
    do_start('h50, 1);
    bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    check("flush_abort_ready", bus.in_ready, 1'b0);
    check("flush_abort_wr", bus.write_to_imem, 1'b1);
    repeat (3) @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("flush_abort_nwr", mon_addr.size(), 1);
    check("flush_abort_done", mon_done.size(), 1);
    check("flush_abort_busy", bus.busy, 1'b0);

    // Reset in the middle of a five-word load
    mon_clear();
    do_start('h60, 5);
    bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_0001;
    @(posedge clk); #1;
    bus.in_data = 32'hDEAD_0002;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_wr", bus.write_to_imem, 1'b0);
    check("mid_rst_addr", bus.addr_imem_host, 9'h0);
    check("mid_rst_data", bus.imem_data, 32'h0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_ready", bus.in_ready, 1'b0);
    check("mid_rst_error", bus.error, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_rst_nwr", mon_addr.size(), 2);
    check("mid_rst_no_done", mon_done.size(), 0);

    // Randomized requests against the model
    for (int r = 0; r < 25; r++) begin
      int b, wc, ab;
      b  = $urandom_range(0, 511);
      wc = $urandom_range(0, 20);
      if (r % 5 == 0) b = 511 - $urandom_range(0, 10);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, wc) : -1;
      txn(b, wc, 2, ab, nw, er);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop so the bench can never hang
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 9: instruction-memory address width (512 words).
REQ-002 Parameter DATA_W, default 32: instruction word width.
REQ-003 Clock and reset SHALL be as follows: one clock, clk; reset, rst, synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-007 abort  input  1  terminate an active load.
REQ-008 base_addr  input  ADDR_W  first imem address; sampled with start.
REQ-009 word_count  input  ADDR_W+1  number of words to load (0..512); sampled with start.
REQ-010 in_valid  input  1  source word present.
REQ-011 in_data  input  DATA_W  source word.
REQ-012 in_ready  output  1  loader accepts in_data this cycle.
REQ-013 write_to_imem  output  1  imem write strobe; also freezes fetch PC.
REQ-014 addr_imem_host  output  ADDR_W  imem write address.
REQ-015 imem_data  output  DATA_W  imem write data.
REQ-016 busy  output  1  high in LOAD and FLUSH.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 error  output  1  sticky range-error flag; cleared by next accepted start.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, FLUSH; next state is IDLE after reset.
REQ-020 IDLE + start: if word_count==0 -> stay IDLE, done=1 next cycle, no writes.
REQ-021 IDLE + start: if base_addr+word_count > 512 (computed at ADDR_W+1 bits) -> stay IDLE, error=1 and done=1 next cycle, no writes.
REQ-022 IDLE + start, otherwise -> LOAD; latch base_addr as write pointer and word_count as remaining count.
REQ-023 in_ready SHALL be 1 exactly when state==LOAD and abort==0; 0 in IDLE and FLUSH.
REQ-024 A word is accepted on an edge where in_valid && in_ready.
REQ-025 Accepted word at edge N: write_to_imem=1 for exactly the cycle after N, with imem_data=in_data and addr_imem_host=write pointer, both registered.
REQ-026 Write pointer increments by 1 and remaining count decrements by 1 per accepted word; the pointer never wraps (REQ-021 guarantees this).
REQ-027 in_valid low in LOAD: no acceptance; write_to_imem=0 the next cycle; pointer and count hold.
REQ-028 Acceptance of the last word (remaining==1) -> FLUSH; FLUSH lasts one cycle while the last write is driven, then -> IDLE with done=1 for one cycle.
REQ-029 Back-to-back acceptance SHALL sustain one write per cycle with no bubbles.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort in LOAD -> IDLE at next edge; the word presented that cycle is not accepted; a write already registered from the previous edge still completes; done=1 next cycle; error unchanged.
REQ-032 abort in IDLE or FLUSH SHALL have no effect.
REQ-033 write_to_imem SHALL be 0 whenever state is IDLE, except during the FLUSH-completing write cycle.

Reset
REQ-034 rst SHALL force: state=IDLE, write_to_imem=0, addr_imem_host=0, imem_data=0, in_ready=0, busy=0, done=0, error=0, pointer=0, count=0.
REQ-035 rst mid-load SHALL drop write_to_imem the next cycle, discard the remaining count, and not pulse done.

Configuration
REQ-036 With macro IMEM_LOADER_CHECKSUM_EN defined: output checksum (DATA_W) SHALL equal the XOR of all words accepted since the last accepted start; cleared to 0 by rst and accepted start; updated at the acceptance edge.
REQ-037 Without IMEM_LOADER_CHECKSUM_EN: no checksum port or logic; all other behaviour identical.

Verification
REQ-038 base=0, count=4, in_valid held high, data 0x11,0x22,0x33,0x44 -> writes at addr 0..3 on 4 consecutive cycles, done one cycle after last write, checksum 0x00000044.
REQ-039 base=0x1FE, count=2 -> writes at 0x1FE, 0x1FF, no error; base=0x1FF, count=2 -> error=1, done=1, zero writes.
REQ-040 count=3, in_valid toggled 1,0,1,0,1 -> exactly 3 writes at base..base+2, write_to_imem low during gaps, pointer held.
REQ-041 count=8, abort after 3 acceptances -> exactly 3 writes, done pulse, busy=0, subsequent start ignored only while busy.
REQ-042 count=0 start -> done next cycle, no write_to_imem, busy never high.
REQ-043 rst asserted after 2 of 5 words -> write_to_imem=0 next cycle, all outputs at reset values, no done pulse.
